// File: rtl/spi_port_scheduler.sv
// Two per-port circular packet queues, round-robin arbitrated onto one shared
// output; each granted packet is held for HOLD cycles for the display stage.
module spi_port_scheduler #(
  parameter int size  = 8,
  parameter int DEPTH = 4,
  parameter int HOLD  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pktValid,
  input  logic                       pktPort,
  input  logic                       pktError,
  input  logic [size-1:0]            pktData,
  output logic                       outValid,
  output logic                       outPort,
  output logic [size-1:0]            outData,
  output logic                       full1,
  output logic                       full2,
  output logic [$clog2(DEPTH):0]     count1,
  output logic [$clog2(DEPTH):0]     count2,
  output logic [7:0]                 dropCount,
  output logic                       errorFlag
);

  // state | meaning
  // IDLE  | nothing on the output, waiting for a queued packet
  // SHOW  | granted packet on outData, hold counter running down to 0

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state, state_nxt;
  logic [size-1:0]   mem [2][DEPTH];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [CW-1:0]     cnt [2];
  logic [1:0]        nonempty, is_full, push, pop;
  logic              drop;
  logic [HW-1:0]     hold_cnt;
  logic              last_served;
  logic              do_grant;
  logic              grant_port;

  assign nonempty = {cnt[1] != '0, cnt[0] != '0};
  assign is_full  = {cnt[1] == CW'(DEPTH), cnt[0] == CW'(DEPTH)};

  // Fullness is judged on the registered count, so a same-cycle pop never makes room.
  always_comb begin
    push = 2'b00;
    drop = 1'b0;
    if (pktValid) begin
      if (pktError || is_full[pktPort]) drop = 1'b1;
      else push[pktPort] = 1'b1;
    end
  end

  assign grant_port = (nonempty == 2'b11) ? ~last_served : nonempty[1];

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (|nonempty) begin
          do_grant  = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (hold_cnt == '0) begin
          if (|nonempty) do_grant = 1'b1;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = do_grant ? (grant_port ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= pktData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        cnt[p]    <= '0;
      end
      outData     <= '0;
      outPort     <= 1'b0;
      hold_cnt    <= '0;
      last_served <= 1'b1;
      dropCount   <= '0;
      errorFlag   <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        if (push[p] && !pop[p])      cnt[p] <= cnt[p] + 1'b1;
        else if (pop[p] && !push[p]) cnt[p] <= cnt[p] - 1'b1;
      end
      if (do_grant) begin
        outData     <= mem[grant_port][rd_ptr[grant_port]];
        outPort     <= grant_port;
        last_served <= grant_port;
        hold_cnt    <= HW'(HOLD - 1);
      end else if (state == SHOW && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (drop && dropCount != 8'hFF) dropCount <= dropCount + 1'b1;
      if (pktValid && pktError) errorFlag <= 1'b1;
    end
  end

  assign outValid = (state == SHOW);
  assign full1    = is_full[0];
  assign full2    = is_full[1];
  assign count1   = cnt[0];
  assign count2   = cnt[1];

endmodule

// File: tb/tb_spi_port_scheduler.sv
// Bench for spi_port_scheduler: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_spi_port_scheduler;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 16;

  logic            clock = 1'b0;
  logic            reset, pktValid, pktPort, pktError;
  logic [SIZE-1:0] pktData;
  logic            outValid, outPort, full1, full2, errorFlag;
  logic [SIZE-1:0] outData;
  logic [2:0]      count1, count2;
  logic [7:0]      dropCount;

  int errors = 0;
  int checks = 0;

  // Reference model: packet queues plus a "cycles shown so far" count.
  logic [SIZE-1:0] mq [2][$];
  bit              m_valid, m_port, m_last, m_err;
  logic [SIZE-1:0] m_data;
  int              m_shown, m_drop;

  spi_port_scheduler #(.size(SIZE), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clock(clock), .reset(reset), .pktValid(pktValid), .pktPort(pktPort),
    .pktError(pktError), .pktData(pktData), .outValid(outValid),
    .outPort(outPort), .outData(outData), .full1(full1), .full2(full2),
    .count1(count1), .count2(count2), .dropCount(dropCount),
    .errorFlag(errorFlag)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    int n0, n1, gp, tgt;
    if (reset) begin
      mq[0].delete(); mq[1].delete();
      m_valid = 0; m_port = 0; m_data = '0; m_shown = 0;
      m_last = 1; m_drop = 0; m_err = 0;
      return;
    end
    n0 = mq[0].size();
    n1 = mq[1].size();
    if (m_valid && m_shown < HOLD) begin
      m_shown++;
    end else if (n0 > 0 || n1 > 0) begin
      gp = (n0 > 0 && n1 > 0) ? (m_last ? 0 : 1) : (n0 > 0 ? 0 : 1);
      m_data  = mq[gp].pop_front();
      m_port  = gp[0];
      m_last  = gp[0];
      m_valid = 1;
      m_shown = 1;
    end else begin
      m_valid = 0;
    end
    if (pktValid) begin
      tgt = pktPort ? n1 : n0;
      if (pktError) begin
        m_err = 1;
        if (m_drop < 255) m_drop++;
      end else if (tgt == DEPTH) begin
        if (m_drop < 255) m_drop++;
      end else begin
        mq[pktPort].push_back(pktData);
      end
    end
  endtask

  task automatic tick(input bit r, input bit v, input bit port, input bit err,
                      input logic [SIZE-1:0] d);
    reset = r; pktValid = v; pktPort = port; pktError = err; pktData = d;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++)
      tick(1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    checks++;
    if ({outValid, outPort, outData, full1, full2, count1, count2, dropCount, errorFlag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b p=%b d=%h f=%b%b c=%0d/%0d drop=%0d err=%b, expected all zero",
               outValid, outPort, outData, full1, full2, count1, count2, dropCount, errorFlag);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, '0);
      checks++;
      if (outValid !== 1'b0 || count1 !== 3'd0 || count2 !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle: got v=%b c1=%0d c2=%0d, expected 0/0/0", outValid, count1, count2);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    tick(0, 1, 0, 0, 8'h2A);
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL single_t1: got outValid=%b, expected 0", outValid);
    end
    for (int i = 0; i < HOLD; i++) begin
      tick(0, 0, 0, 0, '0);
      checks++;
      if (outValid !== 1'b1 || outPort !== 1'b0 || outData !== 8'h2A) begin
        errors++;
        $display("FAIL single_show cyc %0d: got v=%b p=%b d=%h, expected 1/0/2a", i, outValid, outPort, outData);
      end
    end
    tick(0, 0, 0, 0, '0);
    checks++;
    if (outValid !== 1'b0 || outData !== 8'h2A) begin
      errors++; $display("FAIL single_end: got v=%b d=%h, expected 0/2a", outValid, outData);
    end
  endtask

  task automatic test_fairness();
    logic [SIZE-1:0] pk_d [4];
    bit              pk_p [4];
    logic [SIZE-1:0] exp_d [4];
    int c, seg;
    pk_d  = '{8'h11, 8'h21, 8'h12, 8'h22};
    pk_p  = '{0, 1, 0, 1};
    exp_d = '{8'h11, 8'h21, 8'h12, 8'h22};
    do_reset();
    for (int k = 0; k < 4 * HOLD + 6; k++) begin
      if (k < 4) tick(0, 1, pk_p[k], 0, pk_d[k]);
      else tick(0, 0, 0, 0, '0);
      c = k + 1;
      if (c >= 2 && c < 2 + 4 * HOLD) begin
        seg = (c - 2) / HOLD;
        checks++;
        if (outValid !== 1'b1 || outData !== exp_d[seg] || outPort !== seg[0]) begin
          errors++;
          $display("FAIL fairness c%0d: got v=%b p=%b d=%h, expected 1/%0d/%h",
                   c, outValid, outPort, outData, seg % 2, exp_d[seg]);
        end
      end else if (c == 2 + 4 * HOLD) begin
        checks++;
        if (outValid !== 1'b0) begin
          errors++; $display("FAIL fairness_end: got outValid=%b, expected 0", outValid);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int c;
    do_reset();
    for (int k = 0; k < 5 * HOLD + 6; k++) begin
      if (k < 6) tick(0, 1, 1, 0, 8'(k + 1));
      else tick(0, 0, 0, 0, '0);
      c = k + 1;
      if (c == 6) begin
        checks++;
        if (full2 !== 1'b1 || count2 !== 3'd4 || dropCount !== 8'd1) begin
          errors++;
          $display("FAIL overflow_full: got full2=%b count2=%0d drop=%0d, expected 1/4/1", full2, count2, dropCount);
        end
      end
      if (c >= 2 && c < 2 + 5 * HOLD) begin
        checks++;
        if (outValid !== 1'b1 || outPort !== 1'b1 || outData !== 8'((c - 2) / HOLD + 1)) begin
          errors++;
          $display("FAIL overflow_drain c%0d: got v=%b p=%b d=%h, expected 1/1/%h",
                   c, outValid, outPort, outData, 8'((c - 2) / HOLD + 1));
        end
      end else if (c == 2 + 5 * HOLD) begin
        checks++;
        if (outValid !== 1'b0 || count2 !== 3'd0) begin
          errors++; $display("FAIL overflow_end: got v=%b count2=%0d, expected 0/0", outValid, count2);
        end
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    tick(0, 1, 1'($urandom), 1, 8'h7F);
    checks++;
    if (count1 !== 3'd0 || count2 !== 3'd0 || errorFlag !== 1'b1 || dropCount !== 8'd1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL error_pkt: got c=%0d/%0d err=%b drop=%0d v=%b, expected 0/0/1/1/0",
               count1, count2, errorFlag, dropCount, outValid);
    end
    for (int i = 0; i < 300; i++) begin
      tick(0, i < 100, 1'($urandom), 0, 8'($urandom_range(0, 63)));
      checks++;
      if (errorFlag !== 1'b1 || (outValid && outData === 8'h7F) || dropCount !== 8'(m_drop)) begin
        errors++;
        $display("FAIL error_sticky %0d: got err=%b v=%b d=%h drop=%0d, expected err=1 d!=7f drop=%0d",
                 i, errorFlag, outValid, outData, dropCount, m_drop);
      end
    end
    do_reset();
    checks++;
    if (errorFlag !== 1'b0) begin
      errors++; $display("FAIL error_clear: got errorFlag=%b, expected 0", errorFlag);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick(0, 1, 0, 0, 8'(i));
      checks++;
      if (dropCount !== 8'(m_drop)) begin
        errors++; $display("FAIL sat_track %0d: got drop=%0d, expected %0d", i, dropCount, m_drop);
      end
    end
    checks++;
    if (dropCount !== 8'd255) begin
      errors++; $display("FAIL sat_final: got drop=%0d, expected 255", dropCount);
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    tick(0, 1, 0, 0, 8'h31);
    tick(0, 1, 1, 0, 8'h41);
    tick(0, 1, 0, 0, 8'h32);
    tick(0, 1, 1, 0, 8'h42);
    tick(0, 1, 0, 0, 8'h33);
    checks++;
    if (outValid !== 1'b1 || count1 !== 3'd2 || count2 !== 3'd2) begin
      errors++; $display("FAIL midshow_pre: got v=%b c=%0d/%0d, expected 1/2/2", outValid, count1, count2);
    end
    do_reset();
    checks++;
    if (outValid !== 1'b0 || count1 !== 3'd0 || count2 !== 3'd0 || dropCount !== 8'd0 || outData !== 8'h00) begin
      errors++;
      $display("FAIL midshow_reset: got v=%b c=%0d/%0d drop=%0d d=%h, expected all 0",
               outValid, count1, count2, dropCount, outData);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0, '0);
      checks++;
      if (outValid !== 1'b0) begin
        errors++; $display("FAIL midshow_stale %0d: got v=%b d=%h, expected v=0", i, outValid, outData);
      end
    end
    tick(0, 1, 1, 0, 8'h5A);
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL midshow_t1: got v=%b, expected 0", outValid);
    end
    for (int i = 0; i < HOLD; i++) begin
      tick(0, 0, 0, 0, '0);
      checks++;
      if (outValid !== 1'b1 || outPort !== 1'b1 || outData !== 8'h5A) begin
        errors++;
        $display("FAIL midshow_new %0d: got v=%b p=%b d=%h, expected 1/1/5a", i, outValid, outPort, outData);
      end
    end
  endtask

  task automatic test_random();
    bit r, v;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      v = ($urandom_range(0, 99) < 55);
      tick(r, v, 1'($urandom), $urandom_range(0, 99) < 4, 8'($urandom));
      checks++;
      if (outValid !== m_valid || outPort !== m_port || outData !== m_data) begin
        errors++;
        $display("FAIL rnd_out %0d: got v=%b p=%b d=%h, expected %b/%b/%h",
                 i, outValid, outPort, outData, m_valid, m_port, m_data);
      end
      checks++;
      if (count1 !== 3'(mq[0].size()) || count2 !== 3'(mq[1].size()) ||
          full1 !== (mq[0].size() == DEPTH) || full2 !== (mq[1].size() == DEPTH)) begin
        errors++;
        $display("FAIL rnd_queue %0d: got c=%0d/%0d f=%b%b, expected c=%0d/%0d",
                 i, count1, count2, full1, full2, mq[0].size(), mq[1].size());
      end
      checks++;
      if (dropCount !== 8'(m_drop) || errorFlag !== m_err) begin
        errors++;
        $display("FAIL rnd_status %0d: got drop=%0d err=%b, expected %0d/%b",
                 i, dropCount, errorFlag, m_drop, m_err);
      end
    end
  endtask

  initial begin
    reset = 1; pktValid = 0; pktPort = 0; pktError = 0; pktData = '0;
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_error();
    test_saturation();
    test_reset_mid_show();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
